// File: rtl/score_counter_pkg.sv
// score_counter_pkg: shared digit width, glyph geometry and font base for the score counter
package score_counter_pkg;

    localparam int BCD_W = 4;
    localparam int GLYPH_H = 8;
    localparam logic [11:0] FONT_DIGIT_BASE = 12'h180;

    typedef logic [BCD_W-1:0] bcd_t;

    // Glyph ROM row-0 address of a decimal digit, kept at 12 bits so the base never truncates
    function automatic logic [11:0] glyph_addr(input bcd_t v);
        return FONT_DIGIT_BASE + {5'd0, v, 3'd0};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD counter cell with ripple carry; borrow logic only with SCORE_COUNTER_DOWN_EN
module bcd_digit
    import score_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
`ifdef SCORE_COUNTER_DOWN_EN
    input  logic down_i,
`endif
    input  logic carry_i,
    output logic carry_o,
    output bcd_t value_o
);

    bcd_t value_q, value_d;
    logic at_edge;

`ifdef SCORE_COUNTER_DOWN_EN
    assign at_edge = down_i ? (value_q == 4'd0) : (value_q == 4'd9);
`else
    assign at_edge = value_q == 4'd9;
`endif

    // A cell passes the step on only when it is about to roll over
    assign carry_o = carry_i & at_edge;
    assign value_o = value_q;

    // Next value: clear, step with roll-over at the digit boundary, or hold
    always_comb begin
        value_d = value_q;
        if (clr_i)
            value_d = '0;
        else if (carry_i && en_i)
            value_d = at_edge ? 4'd0 : value_q + 4'd1;
`ifdef SCORE_COUNTER_DOWN_EN
        if (!clr_i && carry_i && en_i && down_i)
            value_d = at_edge ? 4'd9 : value_q - 4'd1;
`endif
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (rst)
            value_q <= '0;
        else
            value_q <= value_d;
    end

endmodule

// File: rtl/char_display.sv
// char_display: combinational 8x8 glyph pixel for one character box using the digit font ROM
module char_display
    import score_counter_pkg::*;
(
    input  logic [11:0] x_i,
    input  logic [10:0] y_i,
    input  logic [11:0] box_x_i,
    input  logic [10:0] box_y_i,
    input  logic [11:0] glyph_i,
    output logic        pix_o
);

    // Digits '0'..'9', eight rows each, bit 7 is the leftmost pixel
    localparam logic [7:0] FONT [80] = '{
        8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00,
        8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00
    };

    logic [12:0] dx;
    logic [11:0] dy;
    logic [11:0] addr;
    logic [11:0] idx;
    logic [7:0]  row_bits;
    logic        in_box;

    // Offsets are one bit wider so a pixel left of / above the box wraps far out of range
    always_comb begin
        dx = {1'b0, x_i} - {1'b0, box_x_i};
        dy = {1'b0, y_i} - {1'b0, box_y_i};
        in_box = (dx < 13'd8) && (dy < 12'(GLYPH_H));
        addr = glyph_i + {9'd0, dy[2:0]};
        idx = addr - FONT_DIGIT_BASE;
        row_bits = (idx < 12'd80) ? FONT[idx[6:0]] : 8'h00;
        pix_o = in_box & row_bits[~dx[2:0]];
    end

endmodule

// File: rtl/score_counter.sv
// score_counter: prescaled cascaded BCD score counter with on-screen digits; SCORE_COUNTER_DOWN_EN adds down counting
module score_counter
    import score_counter_pkg::*;
#(
    parameter int          NUM_DIGITS  = 4,
    parameter int          TICK_DIV    = 1,
    parameter int          WRAP        = 1,
    parameter logic [10:0] X_BOX       = 11'd0,
    parameter logic [9:0]  Y_BOX       = 10'd0,
    parameter logic [10:0] DIGIT_PITCH = 11'd8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          clr,
    input  logic                          hold,
`ifdef SCORE_COUNTER_DOWN_EN
    input  logic                          down,
`endif
    input  logic [11:0]                   x,
    input  logic [10:0]                   y,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic                          ovf,
    output logic                          pixel_on
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic                  ovf_q, ovf_d;
    logic                  pix_q, pix_d;
    logic                  accept, step, apply;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] pix_vec;

    // clr and hold both swallow the pulse; only accepted pulses advance the prescaler
    assign accept   = inc & ~hold & ~clr;
    assign step     = accept && (presc_q == PW'(TICK_DIV - 1));
    assign carry[0] = step;
    // Saturating mode blocks the whole step when it would roll out of the top digit
    assign apply    = (WRAP != 0) || !carry[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [11:0] BX = 12'(X_BOX) + 12'((NUM_DIGITS - 1 - i) * DIGIT_PITCH);
        bcd_t value;
        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr),
            .en_i    (apply),
`ifdef SCORE_COUNTER_DOWN_EN
            .down_i  (down),
`endif
            .carry_i (carry[i]),
            .carry_o (carry[i+1]),
            .value_o (value)
        );
        assign digits[BCD_W*i +: BCD_W] = value;
        char_display u_char (
            .x_i     (x),
            .y_i     (y),
            .box_x_i (BX),
            .box_y_i ({1'b0, Y_BOX}),
            .glyph_i (glyph_addr(value)),
            .pix_o   (pix_vec[i])
        );
    end

    assign ovf      = ovf_q;
    assign pixel_on = pix_q;

    // Prescaler, sticky overflow and pixel next-state
    always_comb begin
        presc_d = presc_q;
        if (clr)
            presc_d = '0;
        else if (accept)
            presc_d = step ? '0 : presc_q + PW'(1);
        ovf_d = clr ? 1'b0 : (ovf_q | (step & carry[NUM_DIGITS]));
        pix_d = |pix_vec;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            ovf_q   <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: scoreboard bench for three score_counter configurations (SCORE_COUNTER_DOWN_EN adds down tests)
module tb_score_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  inc, clr, hold;
`ifdef SCORE_COUNTER_DOWN_EN
    logic [2:0]  down;
`endif
    logic [11:0] x;
    logic [10:0] y;
    logic [15:0] dig_a;
    logic [7:0]  dig_b, dig_c;
    logic [2:0]  ovf_o, pix_o;

    always #5 clk = ~clk;

    score_counter #(.NUM_DIGITS(4), .TICK_DIV(1), .WRAP(1), .X_BOX(11'd100), .Y_BOX(10'd50), .DIGIT_PITCH(11'd8)) u_a (
        .clk(clk), .rst(rst), .inc(inc[0]), .clr(clr[0]), .hold(hold[0]),
`ifdef SCORE_COUNTER_DOWN_EN
        .down(down[0]),
`endif
        .x(x), .y(y), .digits(dig_a), .ovf(ovf_o[0]), .pixel_on(pix_o[0]));

    score_counter #(.NUM_DIGITS(2), .TICK_DIV(1), .WRAP(1)) u_b (
        .clk(clk), .rst(rst), .inc(inc[1]), .clr(clr[1]), .hold(hold[1]),
`ifdef SCORE_COUNTER_DOWN_EN
        .down(down[1]),
`endif
        .x(x), .y(y), .digits(dig_b), .ovf(ovf_o[1]), .pixel_on(pix_o[1]));

    score_counter #(.NUM_DIGITS(2), .TICK_DIV(3), .WRAP(0)) u_c (
        .clk(clk), .rst(rst), .inc(inc[2]), .clr(clr[2]), .hold(hold[2]),
`ifdef SCORE_COUNTER_DOWN_EN
        .down(down[2]),
`endif
        .x(x), .y(y), .digits(dig_c), .ovf(ovf_o[2]), .pixel_on(pix_o[2]));

    typedef struct { int kind; logic [15:0] exp; } exp_t;
    typedef struct { logic inc; logic clr; logic hold; logic [15:0] d; logic o; } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] actual(int k);
        case (k)
            0: return dig_a;
            1: return {15'd0, ovf_o[0]};
            2: return {8'd0, dig_b};
            3: return {15'd0, ovf_o[1]};
            4: return {8'd0, dig_c};
            5: return {15'd0, ovf_o[2]};
            default: return {15'd0, pix_o[0]};
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            0: return "a_digits";
            1: return "a_ovf";
            2: return "b_digits";
            3: return "b_ovf";
            4: return "c_digits";
            5: return "c_ovf";
            default: return "a_pixel";
        endcase
    endfunction

    task automatic push(input int k, input logic [15:0] e);
        exp_t t;
        t.kind = k;
        t.exp = e;
        sb.push_back(t);
    endtask

    // Advance one clock, then compare every expectation queued for this edge
    task automatic cyc();
        exp_t t;
        logic [15:0] act;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            act = actual(t.kind);
            checks++;
            if (act !== t.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", kname(t.kind), act, t.exp, $time);
            end
        end
    endtask

    task automatic drive(input int d, input logic i, input logic c, input logic h);
        inc[d] = i;
        clr[d] = c;
        hold[d] = h;
    endtask

    vec_t vecs[10];
    logic [7:0] g7[8];
    logic [7:0] g;
    logic [15:0] e;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0003, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
        g7 = '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00};

        rst = 1'b1;
        inc = '0;
        clr = '0;
        hold = '0;
`ifdef SCORE_COUNTER_DOWN_EN
        down = '0;
`endif
        x = '0;
        y = '0;
        cyc();
        cyc();
        // Reset overrides coincident inc, clr and hold
        inc = '1;
        clr = '1;
        hold = '1;
        for (int k = 0; k <= 6; k++) push(k, 16'h0000);
        cyc();
        rst = 1'b0;
        inc = '0;
        clr = '0;
        hold = '0;

        // Table vectors on the 4-digit counter
        for (int n = 0; n < 10; n++) begin
            drive(0, vecs[n].inc, vecs[n].clr, vecs[n].hold);
            push(0, vecs[n].d);
            push(1, {15'd0, vecs[n].o});
            cyc();
        end

        // Carry ripple through 0x0099 -> 0x0100
        drive(0, 1'b0, 1'b1, 1'b0);
        push(0, 16'h0000);
        cyc();
        for (int n = 1; n <= 100; n++) begin
            drive(0, 1'b1, 1'b0, 1'b0);
            push(0, to_bcd(n));
            push(1, 16'h0000);
            cyc();
        end

        // Count to 0x0042, then inc+clr together: pulse discarded, prescaler cleared
        drive(0, 1'b0, 1'b1, 1'b0);
        push(0, 16'h0000);
        cyc();
        for (int n = 1; n <= 42; n++) begin
            drive(0, 1'b1, 1'b0, 1'b0);
            push(0, to_bcd(n));
            cyc();
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        push(0, 16'h0000);
        push(1, 16'h0000);
        cyc();
        drive(0, 1'b1, 1'b0, 1'b0);
        push(0, 16'h0001);
        cyc();

        // Hold across 5 pulses, then reset during hold
        for (int n = 2; n <= 5; n++) begin
            push(0, to_bcd(n));
            cyc();
        end
        for (int n = 0; n < 5; n++) begin
            drive(0, 1'b1, 1'b0, 1'b1);
            push(0, 16'h0005);
            cyc();
        end
        x = 12'd124;
        y = 11'd50;
        rst = 1'b1;
        push(0, 16'h0000);
        push(1, 16'h0000);
        push(6, 16'h0000);
        cyc();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0);
        push(0, 16'h0001);
        cyc();

        // Two-digit wrap: 99 pulses, then overflow, sticky ovf, clr
        for (int n = 1; n <= 99; n++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            push(2, to_bcd(n));
            push(3, 16'h0000);
            cyc();
        end
        push(2, 16'h0000);
        push(3, 16'h0001);
        cyc();
        push(2, 16'h0001);
        push(3, 16'h0001);
        cyc();
        drive(1, 1'b0, 1'b1, 1'b0);
        push(2, 16'h0000);
        push(3, 16'h0000);
        cyc();
        drive(1, 1'b0, 1'b0, 1'b0);

        // Prescale by 3 with saturation at 99
        for (int n = 1; n <= 303; n++) begin
            drive(2, 1'b1, 1'b0, 1'b0);
            push(4, to_bcd((n / 3 > 99) ? 99 : n / 3));
            push(5, {15'd0, n / 3 > 99});
            cyc();
        end
        drive(2, 1'b0, 1'b1, 1'b0);
        push(4, 16'h0000);
        push(5, 16'h0000);
        cyc();
        // Reset part-way through a prescale period discards the partial count
        drive(2, 1'b1, 1'b0, 1'b0);
        push(4, 16'h0000);
        cyc();
        push(4, 16'h0000);
        cyc();
        rst = 1'b1;
        push(4, 16'h0000);
        cyc();
        rst = 1'b0;
        push(4, 16'h0000);
        cyc();
        push(4, 16'h0000);
        cyc();
        push(4, 16'h0001);
        cyc();
        drive(2, 1'b0, 1'b0, 1'b0);

`ifdef SCORE_COUNTER_DOWN_EN
        // Saturating underflow from 00, then clr
        drive(2, 1'b0, 1'b1, 1'b0);
        down[2] = 1'b1;
        cyc();
        for (int n = 1; n <= 3; n++) begin
            drive(2, 1'b1, 1'b0, 1'b0);
            push(4, 16'h0000);
            push(5, {15'd0, n == 3});
            cyc();
        end
        drive(2, 1'b0, 1'b1, 1'b0);
        push(5, 16'h0000);
        cyc();
        drive(2, 1'b0, 1'b0, 1'b0);
        // Wrapping borrow on the 4-digit counter
        drive(0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(0, 1'b1, 1'b0, 1'b0);
        push(0, 16'h0001);
        cyc();
        down[0] = 1'b1;
        push(0, 16'h0000);
        push(1, 16'h0000);
        cyc();
        push(0, 16'h9999);
        push(1, 16'h0001);
        cyc();
        down[0] = 1'b0;
`endif

        // Glyph for '7' in digit 0's box (x=124..131, y=50..57), blank at x=132
        drive(0, 1'b0, 1'b1, 1'b0);
        cyc();
        for (int n = 1; n <= 7; n++) begin
            drive(0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        push(0, 16'h0007);
        cyc();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c <= 8; c++) begin
                x = 12'(124 + c);
                y = 11'(50 + r);
                g = g7[r];
                e = (c < 8) ? {15'd0, g[7-c]} : 16'h0000;
                push(6, e);
                cyc();
            end
        end
        x = 12'd125;
        y = 11'd58;
        push(6, 16'h0000);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
